// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: takes a PC over valid/ready, does one single-beat AR/R read, and returns the word.
// Defining YSYX_24100005_IFU_HIT_BUF_EN adds a single-entry hit buffer, which is cleared by flush.
module ysyx_24100005_ifu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_valid,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_ready,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic              fetch_err,
    input  logic              inst_ready,
    input  logic              flush,
    output logic              mem_arvalid,
    output logic [ADDR_W-1:0] mem_araddr,
    input  logic              mem_arready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        mem_rresp,
    output logic              mem_rready
);

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        RESP
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              misaligned;
    logic              rd_err;
    logic              hit;
    logic [DATA_W-1:0] hb_data;

    assign misaligned = (pc[1:0] != 2'b00);
    assign rd_err     = (mem_rresp != 2'b00);
    assign mem_araddr = addr_q;

`ifdef YSYX_24100005_IFU_HIT_BUF_EN
    logic              hb_valid;
    logic [ADDR_W-1:0] hb_tag;

    assign hit = hb_valid && (hb_tag == pc);

    // A flush in the same cycle as a fill takes priority, so the entry is left invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_valid <= 1'b0;
            hb_tag   <= '0;
            hb_data  <= '0;
        end else if (flush) begin
            hb_valid <= 1'b0;
        end else if (state == R && mem_rvalid && !rd_err) begin
            hb_valid <= 1'b1;
            hb_tag   <= addr_q;
            hb_data  <= mem_rdata;
        end
    end
`else
    logic unused_flush;

    assign unused_flush = flush;
    assign hit          = 1'b0;
    assign hb_data      = '0;
`endif

    // Handshake outputs are registered alongside the state, so they never depend combinationally on inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc_ready    <= 1'b1;
            inst_valid  <= 1'b0;
            inst        <= '0;
            fetch_err   <= 1'b0;
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b0;
            addr_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_valid) begin
                        addr_q   <= pc;
                        pc_ready <= 1'b0;
                        if (misaligned) begin
                            inst       <= '0;
                            fetch_err  <= 1'b1;
                            inst_valid <= 1'b1;
                            state      <= RESP;
                        end else if (hit) begin
                            inst       <= hb_data;
                            fetch_err  <= 1'b0;
                            inst_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            mem_arvalid <= 1'b1;
                            state       <= AR;
                        end
                    end
                end
                AR: begin
                    if (mem_arready) begin
                        mem_arvalid <= 1'b0;
                        mem_rready  <= 1'b1;
                        state       <= R;
                    end
                end
                R: begin
                    if (mem_rvalid) begin
                        mem_rready <= 1'b0;
                        inst       <= rd_err ? '0 : mem_rdata;
                        fetch_err  <= rd_err;
                        inst_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        pc_ready   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    pc_ready    <= 1'b1;
                    inst_valid  <= 1'b0;
                    mem_arvalid <= 1'b0;
                    mem_rready  <= 1'b0;
                end
            endcase
        end
    end

endmodule
